// File: rtl/sine_sample_analyzer.sv
// ============================================================================
// Module  : sine_sample_analyzer
// Brief   : Measures period, min, max and peak-to-peak of an unsigned sample
//           stream using a hysteresis rising-crossing detector around midscale.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sine_sample_analyzer #(
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 16,
    parameter int MID      = 128,
    parameter int HYST     = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic                sample_valid,
    output logic [PERIOD_W-1:0] meas_period,
    output logic [DATA_W-1:0]   meas_max,
    output logic [DATA_W-1:0]   meas_min,
    output logic [DATA_W-1:0]   meas_ptp,
    output logic                meas_valid,
    output logic                locked,
    output logic                overflow
);

    localparam logic [DATA_W-1:0]   TH      = DATA_W'(MID + HYST);
    localparam logic [DATA_W-1:0]   TL      = DATA_W'(MID - HYST);
    localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                pol;
    logic [PERIOD_W-1:0] cnt;
    logic [DATA_W-1:0]   run_min;
    logic [DATA_W-1:0]   run_max;

    logic above;
    logic below;
    logic crossing;
    logic saturate;

    // Crossing uses the polarity from before this sample updates it.
    assign above    = (sample_in >= TH);
    assign below    = (sample_in <= TL);
    assign crossing = sample_valid & ~pol & above;
    assign saturate = sample_valid & ~crossing & (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEEK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            SEEK:    if (crossing) state_next = MEASURE;
            MEASURE: if (saturate) state_next = SEEK;
            default: state_next = SEEK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pol         <= 1'b1;
            cnt         <= '0;
            run_min     <= '1;
            run_max     <= '0;
            meas_period <= '0;
            meas_max    <= '0;
            meas_min    <= '0;
            meas_ptp    <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (sample_valid) begin
                if (above) begin
                    pol <= 1'b1;
                end else if (below) begin
                    pol <= 1'b0;
                end

                if (crossing) begin
                    // The crossing sample opens the next window.
                    cnt     <= PERIOD_W'(1);
                    run_min <= sample_in;
                    run_max <= sample_in;
                    if (state == MEASURE) begin
                        meas_period <= cnt;
                        meas_min    <= run_min;
                        meas_max    <= run_max;
                        meas_ptp    <= run_max - run_min;
                        meas_valid  <= 1'b1;
                        locked      <= 1'b1;
                    end
                end else if (state == MEASURE) begin
                    if (saturate) begin
                        overflow <= 1'b1;
                        locked   <= 1'b0;
                    end else begin
                        cnt <= cnt + PERIOD_W'(1);
                        if (sample_in < run_min) run_min <= sample_in;
                        if (sample_in > run_max) run_max <= sample_in;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sine_sample_analyzer.sv
// ============================================================================
// Module  : tb_sine_sample_analyzer
// Brief   : Directed self-checking bench for sine_sample_analyzer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sine_sample_analyzer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sample_in = 8'd0;
    logic        sample_valid = 1'b0;

    logic [15:0] meas_period;
    logic [7:0]  meas_max, meas_min, meas_ptp;
    logic        meas_valid, locked, overflow;

    logic [7:0]  meas_period8;
    logic [7:0]  meas_max8, meas_min8, meas_ptp8;
    logic        meas_valid8, locked8, overflow8;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int nvalid      = 0;
    int nvalid8     = 0;
    int last_valid  = 0;
    int gap         = 0;

    logic [7:0] sine [0:31] = '{
        8'd128, 8'd152, 8'd176, 8'd198, 8'd218, 8'd234, 8'd245, 8'd253,
        8'd255, 8'd253, 8'd245, 8'd234, 8'd218, 8'd198, 8'd176, 8'd152,
        8'd128, 8'd103, 8'd79,  8'd57,  8'd37,  8'd21,  8'd10,  8'd2,
        8'd0,   8'd2,   8'd10,  8'd21,  8'd37,  8'd57,  8'd79,  8'd103
    };

    sine_sample_analyzer #(.DATA_W(8), .PERIOD_W(16), .MID(128), .HYST(4)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .meas_period(meas_period), .meas_max(meas_max), .meas_min(meas_min),
        .meas_ptp(meas_ptp), .meas_valid(meas_valid), .locked(locked),
        .overflow(overflow)
    );

    sine_sample_analyzer #(.DATA_W(8), .PERIOD_W(8), .MID(128), .HYST(4)) dut8 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .meas_period(meas_period8), .meas_max(meas_max8), .meas_min(meas_min8),
        .meas_ptp(meas_ptp8), .meas_valid(meas_valid8), .locked(locked8),
        .overflow(overflow8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one clock of stimulus and sample outputs 1 time unit after the edge.
    task automatic step(input logic [7:0] s, input logic v);
        sample_in    = s;
        sample_valid = v;
        @(posedge clk);
        #1;
        cyc++;
        if (meas_valid === 1'b1) begin
            nvalid++;
            gap        = cyc - last_valid;
            last_valid = cyc;
        end
        if (meas_valid8 === 1'b1) nvalid8++;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(8'($urandom), 1'($urandom));
        rst = 1'b0;
    endtask

    task automatic chk_report(input string tag);
        chk({tag, "_period"}, 32'(meas_period), 32);
        chk({tag, "_max"},    32'(meas_max),    255);
        chk({tag, "_min"},    32'(meas_min),    0);
        chk({tag, "_ptp"},    32'(meas_ptp),    255);
        chk({tag, "_locked"}, 32'(locked),      1);
    endtask

    initial begin
        int n0;
        logic [7:0] s;
        logic       mv;

        // Reset values
        rst = 1'b1;
        step(8'($urandom), 1'($urandom));
        step(8'($urandom), 1'($urandom));
        chk("rst_period",   32'(meas_period), 0);
        chk("rst_max",      32'(meas_max),    0);
        chk("rst_min",      32'(meas_min),    0);
        chk("rst_ptp",      32'(meas_ptp),    0);
        chk("rst_valid",    32'(meas_valid),  0);
        chk("rst_locked",   32'(locked),      0);
        chk("rst_overflow", 32'(overflow),    0);
        chk("rst_overflow8", 32'(overflow8),  0);
        rst = 1'b0;
        step(8'd128, 1'b1);
        chk("post_rst_valid", 32'(meas_valid), 0);

        // Full-scale sine, 32 samples/period; crossing lands on k=1 from period 1 on
        for (int p = 0; p <= 4; p++) begin
            for (int k = 0; k < 32; k++) begin
                if (p == 4 && k > 1) break;
                step(sine[k], 1'b1);
                mv = (p >= 2 && k == 1);
                chk("sine_valid", 32'(meas_valid), 32'(mv));
                chk("sine_locked", 32'(locked), 32'(p > 2 || (p == 2 && k >= 1)));
                if (mv) chk_report("sine");
            end
        end
        chk("sine_reports", 32'(nvalid), 3);

        // Noise within the hysteresis band never crosses
        pulse_reset();
        n0 = nvalid;
        for (int i = 0; i < 200; i++) step((i % 2 == 0) ? 8'd126 : 8'd131, 1'b1);
        chk("noise_reports", 32'(nvalid - n0), 0);
        chk("noise_locked",  32'(locked), 0);

        // Square wave, valid every other clock; invalid slots carry 255 which must be ignored
        pulse_reset();
        n0 = nvalid;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 10; i++) begin
                step((i < 5) ? 8'd60 : 8'd200, 1'b1);
                mv = (p >= 1 && i == 5);
                chk("sq_valid", 32'(meas_valid), 32'(mv));
                if (mv) begin
                    chk("sq_period", 32'(meas_period), 10);
                    chk("sq_min",    32'(meas_min),    60);
                    chk("sq_max",    32'(meas_max),    200);
                    chk("sq_ptp",    32'(meas_ptp),    140);
                    if (p >= 2) chk("sq_spacing", 32'(gap), 20);
                end
                step(8'd255, 1'b0);
                chk("sq_gap_valid", 32'(meas_valid), 0);
            end
        end
        chk("sq_reports", 32'(nvalid - n0), 3);

        // Overflow on the 8-bit period instance
        pulse_reset();
        n0 = nvalid8;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 10; i++) step((i < 5) ? 8'd60 : 8'd200, 1'b1);
        end
        chk("ovf_lock_reports", 32'(nvalid8 - n0), 1);
        chk("ovf_lock_period",  32'(meas_period8), 10);
        // 4 highs already follow the crossing; 250 more samples bring cnt to 255
        for (int i = 0; i < 250; i++) step(8'd50, 1'b1);
        chk("ovf_pre_flag",   32'(overflow8), 0);
        chk("ovf_pre_locked", 32'(locked8),   1);
        step(8'd50, 1'b1);
        chk("ovf_flag",    32'(overflow8),    1);
        chk("ovf_locked",  32'(locked8),      0);
        chk("ovf_period",  32'(meas_period8), 10);
        chk("ovf_min",     32'(meas_min8),    60);
        chk("ovf_max",     32'(meas_max8),    200);
        chk("ovf_ptp",     32'(meas_ptp8),    140);
        for (int i = 0; i < 20; i++) step(8'd50, 1'b1);
        chk("ovf_no_report", 32'(nvalid8 - n0), 1);
        chk("ovf_sticky",    32'(overflow8),    1);
        // Resume: first crossing only re-arms from SEEK
        for (int i = 0; i < 10; i++) step((i < 5) ? 8'd60 : 8'd200, 1'b1);
        chk("ovf_silent_crossing", 32'(nvalid8 - n0), 1);
        for (int i = 0; i < 6; i++) step((i < 5) ? 8'd60 : 8'd200, 1'b1);
        chk("ovf_resume_valid",  32'(meas_valid8),  1);
        chk("ovf_resume_period", 32'(meas_period8), 10);
        chk("ovf_resume_locked", 32'(locked8),      1);
        chk("ovf_resume_flag",   32'(overflow8),    1);

        // Reset mid-window aborts measurement
        pulse_reset();
        n0 = nvalid;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 32; k++) begin
                if (p == 2 && k > 20) break;
                step(sine[k], 1'b1);
                if (p == 2 && k == 1) chk_report("mid_pre");
            end
        end
        rst = 1'b1;
        step(sine[21], 1'b1);
        rst = 1'b0;
        chk("mid_rst_period", 32'(meas_period), 0);
        chk("mid_rst_max",    32'(meas_max),    0);
        chk("mid_rst_min",    32'(meas_min),    0);
        chk("mid_rst_ptp",    32'(meas_ptp),    0);
        chk("mid_rst_valid",  32'(meas_valid),  0);
        chk("mid_rst_locked", 32'(locked),      0);
        n0 = nvalid;
        for (int p = 2; p <= 4; p++) begin
            for (int k = (p == 2) ? 22 : 0; k < 32; k++) begin
                if (p == 4 && k > 1) break;
                step(sine[k], 1'b1);
                mv = (p == 4 && k == 1);
                chk("mid_valid", 32'(meas_valid), 32'(mv));
                if (mv) chk_report("mid_post");
            end
        end
        chk("mid_reports", 32'(nvalid - n0), 1);

        s = 8'd0;
        step(s, 1'b0);
        chk("final_valid_drop", 32'(meas_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
